mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 6, memory address width in bits.
REQ-002 The block SHALL expose parameter MEM_WIDTH, default 16, memory data width in bits.
REQ-003 The block SHALL expose parameter TIMEOUT, default 15, max SERVE cycles awaiting ready_i; 0 disables the watchdog.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 mN_valid_i (N=0,1)  input  1  requester N transaction request.
REQ-007 mN_wr_rd_en_i (N=0,1)  input  1  1 = write, 0 = read.
REQ-008 mN_addr_i (N=0,1)  input  ADDR_WIDTH  request address.
REQ-009 mN_wdata_i (N=0,1)  input  MEM_WIDTH  write data.
REQ-010 mN_ready_o (N=0,1)  output  1  one-cycle completion pulse to requester N.
REQ-011 mN_rdata_o (N=0,1)  output  MEM_WIDTH  read data, valid with mN_ready_o on reads.
REQ-012 mN_err_o (N=0,1)  output  1  timeout flag, valid only with mN_ready_o.
REQ-013 valid_o  output  1  request to memory.
REQ-014 wr_rd_en_o  output  1  direction to memory.
REQ-015 addr_o  output  ADDR_WIDTH  address to memory.
REQ-016 wdata_o  output  MEM_WIDTH  write data to memory.
REQ-017 ready_i  input  1  memory acceptance/completion; rdata_i valid when ready_i=1 on reads.
REQ-018 rdata_i  input  MEM_WIDTH  memory read data.
REQ-019 busy_o  output  1  1 when FSM is not IDLE.

Function
REQ-020 FSM SHALL have states IDLE, SERVE, RESP; all outputs SHALL be registered.
REQ-021 IDLE: if any mN_valid_i=1 at a clock edge, grant one requester, capture its wr_rd_en/addr/wdata into valid_o/wr_rd_en_o/addr_o/wdata_o, set valid_o=1, go SERVE; else stay.
REQ-022 Arbitration SHALL be round-robin: single request wins; when both request, the requester not equal to last_owner wins; last_owner SHALL update on every grant.
REQ-023 SERVE: valid_o and memory fields SHALL stay stable until ready_i=1 is sampled; requester inputs SHALL be ignored after grant.
REQ-024 SERVE with ready_i=1: valid_o<=0, owner's mN_ready_o<=1, mN_rdata_o<=rdata_i on reads (unchanged on writes), mN_err_o<=0, go RESP.
REQ-025 Watchdog: counter SHALL clear on grant and increment each SERVE cycle with ready_i=0; on reaching TIMEOUT (TIMEOUT>0): valid_o<=0, owner mN_ready_o<=1, mN_err_o<=1, mN_rdata_o<=0, go RESP.
REQ-026 ready_i=1 on the same edge as the timeout SHALL take priority as a normal completion (no error).
REQ-027 Counter width SHALL be $clog2(TIMEOUT+1), min 1; it SHALL never wrap.
REQ-028 RESP: exactly one cycle; mN_ready_o/mN_err_o clear on exit; no arbitration; go IDLE.
REQ-029 Non-owner mN_ready_o and mN_err_o SHALL remain 0 throughout.
REQ-030 ready_i outside SERVE SHALL be ignored.
REQ-031 Requesters SHALL hold mN_valid_i and fields stable until mN_ready_o; a requester may reassert on the cycle after mN_ready_o.
REQ-032 Latency: request sampled at edge k -> valid_o=1 after edge k; ready_i sampled at edge j -> mN_ready_o=1 after edge j, 0 after j+1; min three cycles per transaction.

Reset
REQ-033 rst_i=0 SHALL immediately force: state IDLE, valid_o=0, wr_rd_en_o=0, addr_o=0, wdata_o=0, mN_ready_o=0, mN_rdata_o=0, mN_err_o=0, busy_o=0, counter=0, last_owner=1 (m0 wins first contention).
REQ-034 Reset mid-transaction SHALL discard the in-flight transaction with no mN_ready_o pulse.

Verification
REQ-035 Single read: m0 reads addr 0x05, memory returns ready_i after 2 cycles with rdata_i=0xA5A5 -> valid_o held 3 cycles, m0_ready_o one pulse, m0_rdata_o=0xA5A5, m0_err_o=0.
REQ-036 Contention: m0 and m1 both write continuously from reset, ready_i tied 1 -> grants alternate m0,m1,m0,m1; each transaction spans 3 cycles.
REQ-037 Timeout: m1 read, ready_i held 0 -> valid_o drops after 15 SERVE cycles, m1_ready_o=1 with m1_err_o=1, m1_rdata_o=0.
REQ-038 Timeout collision: ready_i=1 on the 15th SERVE cycle -> normal completion, m1_err_o=0, rdata captured.
REQ-039 Stability: m0 changes addr from 0x10 to 0x20 while in SERVE -> addr_o stays 0x10 until completion.
REQ-040 Reset mid-SERVE: rst_i=0 while valid_o=1 -> all outputs 0 immediately, no ready pulse; after release, pending m0 and m1 requests -> m0 granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus bundle.
// Requester and memory signals keep their arbiter-facing names.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_WIDTH  = 16
);
  logic                  m0_valid_i;
  logic                  m0_wr_rd_en_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [MEM_WIDTH-1:0]  m0_wdata_i;
  logic                  m0_ready_o;
  logic [MEM_WIDTH-1:0]  m0_rdata_o;
  logic                  m0_err_o;

  logic                  m1_valid_i;
  logic                  m1_wr_rd_en_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [MEM_WIDTH-1:0]  m1_wdata_i;
  logic                  m1_ready_o;
  logic [MEM_WIDTH-1:0]  m1_rdata_o;
  logic                  m1_err_o;

  logic                  valid_o;
  logic                  wr_rd_en_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [MEM_WIDTH-1:0]  wdata_o;
  logic                  ready_i;
  logic [MEM_WIDTH-1:0]  rdata_i;
  logic                  busy_o;

  modport slave (
    input  m0_valid_i, m0_wr_rd_en_i,
    input  m0_addr_i, m0_wdata_i,
    output m0_ready_o, m0_rdata_o, m0_err_o,
    input  m1_valid_i, m1_wr_rd_en_i,
    input  m1_addr_i, m1_wdata_i,
    output m1_ready_o, m1_rdata_o, m1_err_o,
    output valid_o, wr_rd_en_o,
    output addr_o, wdata_o,
    input  ready_i, rdata_i,
    output busy_o
  );

  modport master (
    output m0_valid_i, m0_wr_rd_en_i,
    output m0_addr_i, m0_wdata_i,
    input  m0_ready_o, m0_rdata_o, m0_err_o,
    output m1_valid_i, m1_wr_rd_en_i,
    output m1_addr_i, m1_wdata_i,
    input  m1_ready_o, m1_rdata_o, m1_err_o,
    input  valid_o, wr_rd_en_o,
    input  addr_o, wdata_o,
    output ready_i, rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// IDLE grants, SERVE waits on ready_i or watchdog, RESP pulses ready.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ?
    $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ?
    TIMEOUT - 1 : (2 ** CW) - 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESP
  } state_t;

  state_t                     state_q, state_d;
  logic                       last_q, last_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       valid_q, valid_d;
  logic                       wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [MEM_WIDTH-1:0]       wdata_q, wdata_d;
  logic [1:0]                 rdy_q, rdy_d;
  logic [1:0]                 err_q, err_d;
  logic [1:0][MEM_WIDTH-1:0]  rdata_q, rdata_d;
  logic                       busy_q, busy_d;
  logic                       gnt;
  logic                       any_req;
  logic                       to_hit;

  assign any_req = bus.m0_valid_i | bus.m1_valid_i;
  assign to_hit  = (TIMEOUT > 0) && (cnt_q == LAST);

  // Contention goes to whoever did not own the bus last.
  assign gnt = (bus.m0_valid_i & bus.m1_valid_i) ?
    ~last_q : bus.m1_valid_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          last_d  = gnt;
          cnt_d   = '0;
          valid_d = 1'b1;
          wr_d    = gnt ? bus.m1_wr_rd_en_i
                        : bus.m0_wr_rd_en_i;
          addr_d  = gnt ? bus.m1_addr_i
                        : bus.m0_addr_i;
          wdata_d = gnt ? bus.m1_wdata_i
                        : bus.m0_wdata_i;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (bus.ready_i) begin
          valid_d       = 1'b0;
          rdy_d[last_q] = 1'b1;
          if (!wr_q) rdata_d[last_q] = bus.rdata_i;
          state_d       = RESP;
        end else if (to_hit) begin
          valid_d         = 1'b0;
          rdy_d[last_q]   = 1'b1;
          err_d[last_q]   = 1'b1;
          rdata_d[last_q] = '0;
          state_d         = RESP;
        end else if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.wr_rd_en_o = wr_q;
  assign bus.addr_o     = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.busy_o     = busy_q;
  assign bus.m0_ready_o = rdy_q[0];
  assign bus.m1_ready_o = rdy_q[1];
  assign bus.m0_err_o   = err_q[0];
  assign bus.m1_err_o   = err_q[1];
  assign bus.m0_rdata_o = rdata_q[0];
  assign bus.m1_rdata_o = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, contention, watchdog,
// field stability and asynchronous reset.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_WIDTH(6), .MEM_WIDTH(16)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(6),
    .MEM_WIDTH(16),
    .TIMEOUT(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.m0_valid_i    = 1'b0;
    bus.m0_wr_rd_en_i = 1'b0;
    bus.m0_addr_i     = '0;
    bus.m0_wdata_i    = '0;
    bus.m1_valid_i    = 1'b0;
    bus.m1_wr_rd_en_i = 1'b0;
    bus.m1_addr_i     = '0;
    bus.m1_wdata_i    = '0;
    bus.ready_i       = 1'b0;
    bus.rdata_i       = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_addr", 32'(bus.addr_o), 0);
    chk("rst_m0_rdy", 32'(bus.m0_ready_o), 0);
    chk("rst_m1_err", 32'(bus.m1_err_o), 0);
    tick();
    rst_n = 1'b1;

    // single read, memory answers on third SERVE cycle
    bus.m0_valid_i = 1'b1;
    bus.m0_addr_i  = 6'h05;
    tick();
    chk("rd_valid_c1", 32'(bus.valid_o), 1);
    chk("rd_addr", 32'(bus.addr_o), 'h05);
    chk("rd_dir", 32'(bus.wr_rd_en_o), 0);
    chk("rd_busy", 32'(bus.busy_o), 1);
    tick();
    chk("rd_valid_c2", 32'(bus.valid_o), 1);
    tick();
    chk("rd_valid_c3", 32'(bus.valid_o), 1);
    chk("rd_no_early_rdy", 32'(bus.m0_ready_o), 0);
    bus.ready_i = 1'b1;
    bus.rdata_i = 16'hA5A5;
    tick();
    chk("rd_rdy", 32'(bus.m0_ready_o), 1);
    chk("rd_rdata", 32'(bus.m0_rdata_o), 'hA5A5);
    chk("rd_err", 32'(bus.m0_err_o), 0);
    chk("rd_valid_drop", 32'(bus.valid_o), 0);
    chk("rd_m1_rdy", 32'(bus.m1_ready_o), 0);
    bus.ready_i    = 1'b0;
    bus.m0_valid_i = 1'b0;
    tick();
    chk("rd_rdy_pulse", 32'(bus.m0_ready_o), 0);
    chk("rd_idle_busy", 32'(bus.busy_o), 0);

    // contention from reset, ready tied high
    rst_n = 1'b0;
    #1;
    chk("rst2_rdata", 32'(bus.m0_rdata_o), 0);
    tick();
    rst_n = 1'b1;
    bus.m0_valid_i    = 1'b1;
    bus.m0_wr_rd_en_i = 1'b1;
    bus.m0_addr_i     = 6'h01;
    bus.m0_wdata_i    = 16'h1111;
    bus.m1_valid_i    = 1'b1;
    bus.m1_wr_rd_en_i = 1'b1;
    bus.m1_addr_i     = 6'h02;
    bus.m1_wdata_i    = 16'h2222;
    bus.ready_i       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_addr", 32'(bus.addr_o), (i % 2) ? 2 : 1);
      chk("rr_wdata", 32'(bus.wdata_o),
          (i % 2) ? 'h2222 : 'h1111);
      chk("rr_valid", 32'(bus.valid_o), 1);
      tick();
      chk("rr_m0_rdy", 32'(bus.m0_ready_o),
          (i % 2) ? 0 : 1);
      chk("rr_m1_rdy", 32'(bus.m1_ready_o),
          (i % 2) ? 1 : 0);
      tick();
      chk("rr_resp_exit", 32'(bus.valid_o | bus.m0_ready_o
          | bus.m1_ready_o), 0);
    end
    bus.m0_valid_i = 1'b0;
    bus.m1_valid_i = 1'b0;
    bus.ready_i    = 1'b0;
    tick();

    // ready on the 15th SERVE cycle wins over the watchdog
    bus.m1_valid_i    = 1'b1;
    bus.m1_wr_rd_en_i = 1'b0;
    bus.m1_addr_i     = 6'h03;
    tick();
    chk("col_addr", 32'(bus.addr_o), 'h03);
    for (int i = 0; i < 14; i++) tick();
    chk("col_valid_c15", 32'(bus.valid_o), 1);
    bus.ready_i = 1'b1;
    bus.rdata_i = 16'hBEEF;
    tick();
    chk("col_rdy", 32'(bus.m1_ready_o), 1);
    chk("col_err", 32'(bus.m1_err_o), 0);
    chk("col_rdata", 32'(bus.m1_rdata_o), 'hBEEF);
    bus.ready_i    = 1'b0;
    bus.m1_valid_i = 1'b0;
    tick();
    chk("col_rdy_clr", 32'(bus.m1_ready_o), 0);

    // watchdog expiry
    bus.m1_valid_i = 1'b1;
    bus.m1_addr_i  = 6'h04;
    bus.rdata_i    = 16'h7777;
    tick();
    chk("to_valid_c1", 32'(bus.valid_o), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_valid_hold", 32'(bus.valid_o), 1);
    end
    tick();
    chk("to_valid_drop", 32'(bus.valid_o), 0);
    chk("to_rdy", 32'(bus.m1_ready_o), 1);
    chk("to_err", 32'(bus.m1_err_o), 1);
    chk("to_rdata", 32'(bus.m1_rdata_o), 0);
    chk("to_m0_rdy", 32'(bus.m0_ready_o), 0);
    bus.m1_valid_i = 1'b0;
    tick();
    chk("to_err_clr", 32'(bus.m1_err_o), 0);
    chk("to_rdy_clr", 32'(bus.m1_ready_o), 0);

    // memory fields frozen after grant
    bus.m0_valid_i    = 1'b1;
    bus.m0_wr_rd_en_i = 1'b1;
    bus.m0_addr_i     = 6'h10;
    bus.m0_wdata_i    = 16'h1234;
    tick();
    chk("st_addr_c1", 32'(bus.addr_o), 'h10);
    bus.m0_addr_i  = 6'h20;
    bus.m0_wdata_i = 16'h5678;
    tick();
    chk("st_addr_c2", 32'(bus.addr_o), 'h10);
    chk("st_wdata_c2", 32'(bus.wdata_o), 'h1234);
    bus.ready_i = 1'b1;
    bus.rdata_i = 16'hFFFF;
    tick();
    chk("st_rdy", 32'(bus.m0_ready_o), 1);
    chk("st_wr_rdata", 32'(bus.m0_rdata_o), 0);
    bus.ready_i    = 1'b0;
    bus.m0_valid_i = 1'b0;
    tick();

    // reset during SERVE, then m0 wins first contention
    bus.m1_valid_i = 1'b1;
    bus.m1_addr_i  = 6'h07;
    tick();
    chk("rs_valid_pre", 32'(bus.valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid", 32'(bus.valid_o), 0);
    chk("rs_addr", 32'(bus.addr_o), 0);
    chk("rs_busy", 32'(bus.busy_o), 0);
    bus.m0_valid_i    = 1'b1;
    bus.m0_wr_rd_en_i = 1'b0;
    bus.m0_addr_i     = 6'h09;
    tick();
    chk("rs_no_rdy", 32'(bus.m1_ready_o | bus.m0_ready_o), 0);
    rst_n = 1'b1;
    tick();
    chk("rs_first_gnt", 32'(bus.addr_o), 'h09);
    bus.ready_i = 1'b1;
    bus.rdata_i = 16'h0042;
    tick();
    chk("rs_m0_rdy", 32'(bus.m0_ready_o), 1);
    chk("rs_m1_rdy", 32'(bus.m1_ready_o), 0);
    chk("rs_m0_rdata", 32'(bus.m0_rdata_o), 'h0042);
    bus.ready_i    = 1'b0;
    bus.m0_valid_i = 1'b0;
    bus.m1_valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
